// File: rtl/struct_req_mem.sv
// Request-FIFO-fronted word memory: in-order {addr,data,wr} requests, registered read responses.
// Optional macro STRUCT_REQ_MEM_PARITY_EN adds per-entry even parity with perr_inject/rsp_perr.
module struct_req_mem #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W     = $clog2(FIFO_DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_wr,
`ifdef STRUCT_REQ_MEM_PARITY_EN
  input  logic              perr_inject,
  output logic              rsp_perr,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic [CNT_W-1:0]  fifo_count
);
  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr;
`ifdef STRUCT_REQ_MEM_PARITY_EN
    logic              inj;
`endif
  } req_t;

  req_t              fifo_q [FIFO_DEPTH];
  req_t              req_in, head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              full, empty, push, pop;
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [MEM_WORDS-1:0] vbits;
  logic              hit;

  always_comb begin
    req_in      = '0;
    req_in.addr = req_addr;
    req_in.data = req_data;
    req_in.wr   = req_wr;
`ifdef STRUCT_REQ_MEM_PARITY_EN
    req_in.inj  = perr_inject;
`endif
  end

  assign head      = fifo_q[rd_ptr];
  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign empty     = (fifo_count == '0);
  assign req_ready = rst_n && !full && !clear;
  assign push      = req_valid && req_ready;
  assign pop       = !empty && !clear && (!rsp_valid || rsp_ready);
  assign hit       = vbits[head.addr];

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= req_in;
  end

  // Data array carries no reset; vbits masks stale contents.
  always_ff @(posedge clk) begin
    if (pop && head.wr) mem[head.addr] <= head.data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                vbits <= '0;
    else if (clear)            vbits <= '0;
    else if (pop && head.wr)   vbits[head.addr] <= 1'b1;
  end

`ifdef STRUCT_REQ_MEM_PARITY_EN
  logic [MEM_WORDS-1:0] par_q;
  logic                 perr;

  always_ff @(posedge clk) begin
    if (pop && head.wr) par_q[head.addr] <= (^head.data) ^ head.inj;
  end

  assign perr = hit && (par_q[head.addr] != (^mem[head.addr]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rsp_perr <= 1'b0;
    else if (clear)            rsp_perr <= 1'b0;
    else if (pop && !head.wr)  rsp_perr <= perr;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_hit   <= 1'b0;
    end else if (clear) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_hit   <= 1'b0;
    end else if (pop && !head.wr) begin
      rsp_valid <= 1'b1;
      rsp_hit   <= hit;
      rsp_data  <= hit ? mem[head.addr] : '0;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_struct_req_mem.sv
// Vector table plus hand sequences; read expectations queued at acceptance, checked on handshake.
module tb_struct_req_mem;
  logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic       req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b1;
  logic [7:0] req_addr = '0, req_data = '0;
  logic       req_ready, rsp_valid, rsp_hit;
  logic [7:0] rsp_data;
  logic [2:0] fifo_count;
  logic       perr_inject = 1'b0;
`ifdef STRUCT_REQ_MEM_PARITY_EN
  logic       rsp_perr;
`endif

  struct_req_mem #(.ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_wr(req_wr),
`ifdef STRUCT_REQ_MEM_PARITY_EN
    .perr_inject(perr_inject), .rsp_perr(rsp_perr),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_hit(rsp_hit), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [7:0] addr, data, ed; logic eh; } vec_t;
  typedef struct { logic [7:0] d; logic h; logic p; } exp_t;

  vec_t vt[13];
  exp_t sb[$];
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Handshake happens at the following posedge; inputs only change just after posedges.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_unexpected data=%0h t=%0t", rsp_data, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(e.d));
        chk("rsp_hit",  32'(rsp_hit),  32'(e.h));
`ifdef STRUCT_REQ_MEM_PARITY_EN
        chk("rsp_perr", 32'(rsp_perr), 32'(e.p));
`endif
      end
    end
  end

  task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] ed, input logic eh,
                      input logic inj = 1'b0, input logic ep = 1'b0);
    bit acc = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_data = d; perr_inject = inj;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1;
        if (!wr) sb.push_back('{d: ed, h: eh, p: ep});
      end
      @(posedge clk); #1;
    end
    if (!acc) begin total++; bad++; $display("FAIL send_timeout addr=%0h", a); end
    req_valid = 1'b0; perr_inject = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain_left", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] held;
    vt[0]  = '{0, 8'h05, 8'h00, 8'h00, 0};
    vt[1]  = '{1, 8'h80, 8'hFF, 8'h00, 0};
    vt[2]  = '{0, 8'h80, 8'h00, 8'hFF, 1};
    vt[3]  = '{1, 8'h10, 8'hAA, 8'h00, 0};
    vt[4]  = '{1, 8'h10, 8'h55, 8'h00, 0};
    vt[5]  = '{0, 8'h10, 8'h00, 8'h55, 1};
    vt[6]  = '{1, 8'h3C, 8'h5A, 8'h00, 0};
    vt[7]  = '{0, 8'h3C, 8'h00, 8'h5A, 1};
    vt[8]  = '{0, 8'h3D, 8'h00, 8'h00, 0};
    vt[9]  = '{1, 8'h00, 8'h01, 8'h00, 0};
    vt[10] = '{0, 8'h00, 8'h00, 8'h01, 1};
    vt[11] = '{1, 8'hFF, 8'h7E, 8'h00, 0};
    vt[12] = '{0, 8'hFF, 8'h00, 8'h7E, 1};

    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_hit", 32'(rsp_hit), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) send(vt[i].wr, vt[i].addr, vt[i].data, vt[i].ed, vt[i].eh);
    drain();

    // Latency: response valid one edge after the read is accepted, for one cycle.
    send(1, 8'h80, 8'hFF, 8'h00, 0);
    send(0, 8'h80, 8'h00, 8'hFF, 1);
    chk("lat_before", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    chk("lat_valid", 32'(rsp_valid), 1);
    @(posedge clk); #1;
    chk("lat_fall", 32'(rsp_valid), 0);
    drain();

    // Backpressure: one response held plus four queued fills everything.
    rsp_ready = 1'b0;
    send(0, 8'h80, 8'h00, 8'hFF, 1);
    send(0, 8'h10, 8'h00, 8'h55, 1);
    send(0, 8'h3C, 8'h00, 8'h5A, 1);
    send(0, 8'h05, 8'h00, 8'h00, 0);
    send(0, 8'h00, 8'h00, 8'h01, 1);
    chk("bp_count", 32'(fifo_count), 4);
    chk("bp_ready", 32'(req_ready), 0);
    held = rsp_data;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall_ready", 32'(req_ready), 0);
      chk("bp_hold_data", 32'(rsp_data), 32'(held));
      chk("bp_hold_valid", 32'(rsp_valid), 1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(0, 8'hFF, 8'h00, 8'h7E, 1);
    drain();

    // Overwrite then flush with requests in flight.
    send(1, 8'h10, 8'hAA, 8'h00, 0);
    send(1, 8'h10, 8'h55, 8'h00, 0);
    send(0, 8'h10, 8'h00, 8'h55, 1);
    drain();
    rsp_ready = 1'b0;
    send(0, 8'h10, 8'h00, 8'h55, 1);
    send(0, 8'h10, 8'h00, 8'h55, 1);
    send(0, 8'h10, 8'h00, 8'h55, 1);
    chk("clr_pre_count", 32'(fifo_count), 2);
    chk("clr_pre_valid", 32'(rsp_valid), 1);
    clear = 1'b1;
    @(negedge clk);
    chk("clr_req_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    sb.delete();
    chk("clr_count", 32'(fifo_count), 0);
    chk("clr_rsp_valid", 32'(rsp_valid), 0);
    chk("clr_rsp_hit", 32'(rsp_hit), 0);
    rsp_ready = 1'b1;
    send(0, 8'h10, 8'h00, 8'h00, 0);
    drain();

    // Asynchronous reset mid-burst.
    send(1, 8'h80, 8'h33, 8'h00, 0);
    rsp_ready = 1'b0;
    send(0, 8'h80, 8'h00, 8'h33, 1);
    send(0, 8'h80, 8'h00, 8'h33, 1);
    send(0, 8'h80, 8'h00, 8'h33, 1);
    chk("arst_pre_valid", 32'(rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_count", 32'(fifo_count), 0);
    chk("arst_req_ready", 32'(req_ready), 0);
    sb.delete();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(0, 8'h80, 8'h00, 8'h00, 0);
    drain();

`ifdef STRUCT_REQ_MEM_PARITY_EN
    send(1, 8'h20, 8'h0F, 8'h00, 0, 1'b1);
    send(0, 8'h20, 8'h00, 8'h0F, 1, 1'b0, 1'b1);
    send(1, 8'h20, 8'h0F, 8'h00, 0, 1'b0);
    send(0, 8'h20, 8'h00, 8'h0F, 1, 1'b0, 1'b0);
    send(0, 8'h21, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
